// File: rtl/clkdiv_cfg_ctrl.sv
// Sequencing controller for the integer clock divider: takes ratio/enable requests
// over valid/ready and applies them by draining, gating and re-locking the divider.
module clkdiv_cfg_ctrl #(
    parameter int ratio_width   = 4,
    parameter int DEFAULT_RATIO = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int LOCK_EDGES    = 2,
    parameter int DRAIN_TIMEOUT = 32
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic                   i_cfg_valid,
    input  logic [ratio_width-1:0] i_cfg_ratio,
    output logic                   o_cfg_ready,
    output logic                   o_cfg_done,
    output logic                   o_cfg_err,
    input  logic                   i_div_clk,
    output logic [ratio_width-1:0] o_div_ratio,
    output logic                   o_clk_en,
    output logic                   o_div_rst_n,
    output logic                   o_locked,
    output logic                   o_busy
);

    localparam int CNT_MAX = (DRAIN_TIMEOUT > SETTLE_CYCLES) ? DRAIN_TIMEOUT : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam int EW      = $clog2(LOCK_EDGES) + 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_SETTLE,
        S_LOCKING,
        S_RUN,
        S_DRAIN,
        S_GATE
    } state_t;

    state_t                 state, next_state;
    logic                   div_clk_q;
    logic                   pending;
    logic                   target_run;
    logic [ratio_width-1:0] pending_ratio;
    logic [CW-1:0]          cnt;
    logic [EW-1:0]          edges;

    logic xfer, ratio_bad, ratio_same, rise;
    logic settle_done, lock_done, drain_timeout;

    assign o_cfg_ready   = !i_rst && !pending && (state == S_OFF || state == S_RUN);
    assign o_busy        = !(state == S_OFF || state == S_RUN);
    assign xfer          = i_cfg_valid && o_cfg_ready;
    assign ratio_bad     = i_cfg_ratio < ratio_width'(2);
    assign ratio_same    = i_cfg_ratio == o_div_ratio;
    assign rise          = i_div_clk && !div_clk_q;
    assign settle_done   = cnt == CW'(SETTLE_CYCLES - 1);
    assign lock_done     = rise && (edges == EW'(LOCK_EDGES - 1));
    assign drain_timeout = i_div_clk && (cnt == CW'(DRAIN_TIMEOUT - 1));

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            S_OFF:     if (i_enable) next_state = S_SETTLE;
            S_SETTLE:  if (!i_enable) next_state = S_OFF;
                       else if (settle_done) next_state = S_LOCKING;
            S_LOCKING: if (!i_enable) next_state = S_DRAIN;
                       else if (lock_done) next_state = S_RUN;
            S_RUN:     if (!i_enable || (xfer && !ratio_bad && !ratio_same)) next_state = S_DRAIN;
            S_DRAIN:   if (!i_div_clk || drain_timeout) next_state = S_GATE;
            S_GATE:    next_state = (target_run && i_enable) ? S_SETTLE : S_OFF;
            default:   next_state = S_OFF;
        endcase
    end

    // NOTE: all state and outputs here use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state         <= S_OFF;
            div_clk_q     <= 1'b0;
            pending       <= 1'b0;
            target_run    <= 1'b0;
            pending_ratio <= ratio_width'(DEFAULT_RATIO);
            cnt           <= '0;
            edges         <= '0;
            o_div_ratio   <= ratio_width'(DEFAULT_RATIO);
            o_clk_en      <= 1'b0;
            o_div_rst_n   <= 1'b0;
            o_locked      <= 1'b0;
            o_cfg_done    <= 1'b0;
            o_cfg_err     <= 1'b0;
        end else begin
            state     <= next_state;
            div_clk_q <= i_div_clk;
            cnt       <= (next_state != state) ? '0 : cnt + CW'(1);

            if (state != S_LOCKING)  edges <= '0;
            else if (rise)           edges <= edges + EW'(1);

            // Divider controls follow the state being entered, so they come straight from flops.
            o_clk_en    <= next_state inside {S_LOCKING, S_RUN, S_DRAIN};
            o_div_rst_n <= next_state inside {S_SETTLE, S_LOCKING, S_RUN, S_DRAIN};
            o_locked    <= next_state == S_RUN;

            o_cfg_done <= 1'b0;
            o_cfg_err  <= (state == S_DRAIN) && drain_timeout;

            if ((state == S_LOCKING || state == S_RUN) && next_state == S_DRAIN)
                target_run <= i_enable;

            if (xfer) begin
                if (ratio_bad) begin
                    o_cfg_err <= 1'b1;
                end else if (state == S_OFF) begin
                    o_div_ratio <= i_cfg_ratio;
                    o_cfg_done  <= 1'b1;
                end else if (ratio_same) begin
                    o_cfg_done <= 1'b1;
                end else begin
                    pending       <= 1'b1;
                    pending_ratio <= i_cfg_ratio;
                end
            end

            // New ratio lands while the divider is held in reset for the GATE cycle.
            if (next_state == S_GATE && pending)
                o_div_ratio <= pending_ratio;

            if (pending && next_state != state && (next_state == S_RUN || next_state == S_OFF)) begin
                o_cfg_done <= 1'b1;
                pending    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Directed bench for clkdiv_cfg_ctrl with a behavioural divider closing the i_div_clk loop.
// Divider model: counts 0..ratio-1, output high for ratio/2 cycles after each wrap.
module tb_clkdiv_cfg_ctrl;

    logic       i_ref_clk = 1'b0;
    logic       i_rst;
    logic       i_enable;
    logic       i_cfg_valid;
    logic [3:0] i_cfg_ratio;
    logic       o_cfg_ready, o_cfg_done, o_cfg_err;
    logic       i_div_clk;
    logic [3:0] o_div_ratio;
    logic       o_clk_en, o_div_rst_n, o_locked, o_busy;

    logic [3:0] dcnt, dnext;
    logic       dq;
    logic       force_hi;

    int checks = 0;
    int errors = 0;

    always #5 i_ref_clk = ~i_ref_clk;

    clkdiv_cfg_ctrl dut (
        .i_ref_clk  (i_ref_clk),
        .i_rst      (i_rst),
        .i_enable   (i_enable),
        .i_cfg_valid(i_cfg_valid),
        .i_cfg_ratio(i_cfg_ratio),
        .o_cfg_ready(o_cfg_ready),
        .o_cfg_done (o_cfg_done),
        .o_cfg_err  (o_cfg_err),
        .i_div_clk  (i_div_clk),
        .o_div_ratio(o_div_ratio),
        .o_clk_en   (o_clk_en),
        .o_div_rst_n(o_div_rst_n),
        .o_locked   (o_locked),
        .o_busy     (o_busy)
    );

    assign dnext     = (dcnt == o_div_ratio - 4'd1) ? 4'd0 : dcnt + 4'd1;
    assign i_div_clk = dq | force_hi;

    always_ff @(posedge i_ref_clk) begin
        if (!o_div_rst_n) begin
            dcnt <= 4'd0;
            dq   <= 1'b0;
        end else if (o_clk_en) begin
            dcnt <= dnext;
            dq   <= dnext < (o_div_ratio >> 1);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge i_ref_clk);
    endtask

    task automatic send(input logic [3:0] r);
        i_cfg_valid = 1'b1;
        i_cfg_ratio = r;
        step();
        i_cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && !o_cfg_done; k++) step();
    endtask

    task automatic wait_locked(input int budget);
        for (int k = 0; k < budget && !o_locked; k++) step();
    endtask

    task automatic measure(output int period, output int high);
        logic p;
        period = 0;
        high   = 0;
        p      = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (i_div_clk && !p) break;
            p = i_div_clk;
        end
        for (int k = 0; k < 40; k++) begin
            if (i_div_clk) high++;
            period++;
            p = i_div_clk;
            step();
            if (i_div_clk && !p) break;
        end
    endtask

    initial begin
        int n, per, hi, extra;
        logic prev;

        i_rst       = 1'b1;
        i_enable    = 1'b0;
        i_cfg_valid = 1'b0;
        i_cfg_ratio = 4'd0;
        force_hi    = 1'b0;
        repeat (3) step();

        check("rst_ratio",  o_div_ratio, 2);
        check("rst_en",     o_clk_en, 0);
        check("rst_rstn",   o_div_rst_n, 0);
        check("rst_locked", o_locked, 0);
        check("rst_ready",  o_cfg_ready, 0);
        check("rst_busy",   o_busy, 0);

        i_rst = 1'b0;
        step();
        check("off_ready", o_cfg_ready, 1);

        // Power-up at default ratio 2
        i_enable = 1'b1;
        step();
        check("settle_rstn", o_div_rst_n, 1);
        check("settle_en",   o_clk_en, 0);
        check("settle_busy", o_busy, 1);
        step();
        check("settle2_en", o_clk_en, 0);
        step();
        check("locking_en", o_clk_en, 1);
        n = 0;
        while (!o_locked && n < 50) begin step(); n++; end
        check("lock_cycles", n, 5);
        measure(per, hi);
        check("period2", per, 2);
        check("high2",   hi, 1);

        // Ratio change 2 -> 5
        send(4'd5);
        check("chg_ready", o_cfg_ready, 0);
        check("chg_busy",  o_busy, 1);
        n = 0;
        prev = i_div_clk;
        while (o_div_rst_n && n < 40) begin prev = i_div_clk; step(); n++; end
        check("gate_rstn",     o_div_rst_n, 0);
        check("gate_en",       o_clk_en, 0);
        check("gate_div_low",  prev, 0);
        check("gate_ratio",    o_div_ratio, 5);
        step();
        check("gate_one_cyc",  o_div_rst_n, 1);
        wait_done(80);
        check("chg_done",   o_cfg_done, 1);
        check("chg_locked", o_locked, 1);
        check("chg_ratio",  o_div_ratio, 5);
        measure(per, hi);
        check("period5", per, 5);
        check("high5",   hi, 2);

        // Invalid ratios
        send(4'd1);
        check("r1_err",    o_cfg_err, 1);
        check("r1_ratio",  o_div_ratio, 5);
        check("r1_locked", o_locked, 1);
        send(4'd0);
        check("r0_err",    o_cfg_err, 1);
        check("r0_ratio",  o_div_ratio, 5);
        check("r0_locked", o_locked, 1);
        check("r0_ready",  o_cfg_ready, 1);

        // Same ratio no-op
        send(4'd5);
        check("same_done",   o_cfg_done, 1);
        check("same_locked", o_locked, 1);
        check("same_busy",   o_busy, 0);

        // Go to 7, then enable falls together with request 3
        send(4'd7);
        wait_done(80);
        check("r7_done", o_cfg_done, 1);
        i_enable = 1'b0;
        send(4'd3);
        wait_done(80);
        check("off_done",   o_cfg_done, 1);
        check("off_en",     o_clk_en, 0);
        check("off_rstn",   o_div_rst_n, 0);
        check("off_ratio",  o_div_ratio, 3);
        check("off_state",  o_busy, 0);
        check("off_locked", o_locked, 0);
        extra = 0;
        repeat (8) begin step(); if (o_cfg_done) extra++; end
        check("off_done_once", extra, 0);
        i_enable = 1'b1;
        wait_locked(80);
        check("relock", o_locked, 1);
        measure(per, hi);
        check("period3", per, 3);
        check("high3",   hi, 1);

        // Drain timeout with i_div_clk stuck high
        force_hi = 1'b1;
        send(4'd4);
        n = 1;
        while (!o_cfg_err && n < 100) begin step(); n++; end
        check("to_cycles", n, 33);
        check("to_err",    o_cfg_err, 1);
        check("to_rstn",   o_div_rst_n, 0);
        check("to_ratio",  o_div_ratio, 4);
        force_hi = 1'b0;

        // Reset in the middle of LOCKING, pending request dropped
        n = 0;
        while (!o_clk_en && n < 20) begin step(); n++; end
        check("lk_en",     o_clk_en, 1);
        check("lk_locked", o_locked, 0);
        i_rst = 1'b1;
        step();
        check("mr_ratio",  o_div_ratio, 2);
        check("mr_en",     o_clk_en, 0);
        check("mr_rstn",   o_div_rst_n, 0);
        check("mr_locked", o_locked, 0);
        check("mr_ready",  o_cfg_ready, 0);
        check("mr_done",   o_cfg_done, 0);
        check("mr_busy",   o_busy, 0);
        i_enable = 1'b0;
        i_rst    = 1'b0;
        step();
        check("mr_ready_after", o_cfg_ready, 1);
        extra = 0;
        repeat (5) begin if (o_cfg_done) extra++; step(); end
        check("mr_no_done", extra, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
